// File: rtl/fir_phase_sequencer.sv
// Serial 64-phase FIR engine for one equalizer band.
// Accepts one sample, shifts it into the delay line, then walks the phases
// doing one MAC per enabled cycle against an external combinational ROM.
// The saturated Q1.15 result is presented on a valid/ready output port.
module fir_phase_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int ACC_WIDTH   = 40,
  parameter int PHASE_WIDTH = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clk_enable,
  input  logic        [DATA_WIDTH-1:0]  in_sample,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic        [PHASE_WIDTH-1:0] coeff_addr,
  input  logic signed [COEFF_WIDTH-1:0] coeff_in,
  output logic        [DATA_WIDTH-1:0]  out_sample,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic        [PHASE_WIDTH-1:0] current_count,
  output logic                          phase_0,
  output logic                          phase_63
);

  localparam int NPH    = 1 << PHASE_WIDTH;
  localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
  localparam logic [PHASE_WIDTH-1:0] LAST_PH = PHASE_WIDTH'(NPH - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  state_e                        state_q, state_d;
  logic        [PHASE_WIDTH-1:0] cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0]  x_q [NPH];
  logic        [DATA_WIDTH-1:0]  out_q, out_d;
  logic                          ov_q, ov_d;

  logic                          accept, step, last;
  logic signed [PROD_W-1:0]      prod;
  logic signed [ACC_WIDTH-1:0]   prod_ext, sum, shifted;
  logic        [DATA_WIDTH-1:0]  sat;

  assign accept = in_valid && in_ready;
  assign step   = clk_enable && (state_q == RUN);
  assign last   = step && (cnt_q == LAST_PH);

  // MAC datapath: full-precision product, sign-extended into the accumulator
  always_comb begin
    prod     = x_q[cnt_q] * coeff_in;
    prod_ext = {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};
    sum      = acc_q + prod_ext;
    shifted  = sum >>> (COEFF_WIDTH-1);
    if (shifted > SAT_MAX)      sat = SAT_MAX[DATA_WIDTH-1:0];
    else if (shifted < SAT_MIN) sat = SAT_MIN[DATA_WIDTH-1:0];
    else                        sat = shifted[DATA_WIDTH-1:0];
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: IDLE -> RUN on accept, RUN -> IDLE after the last phase
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = RUN;
      RUN:  if (last)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: accept only when the result slot is free or draining now
  always_comb begin
    in_ready = rst && clk_enable && (state_q == IDLE) && (!ov_q || out_ready);
    busy     = (state_q == RUN);
    phase_0  = busy && (cnt_q == '0);
    phase_63 = busy && (cnt_q == LAST_PH);
  end

  // Datapath next state: phase counter, accumulator, result slot
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    out_d = out_q;
    ov_d  = ov_q;
    if (clk_enable && ov_q && out_ready) ov_d = 1'b0;
    if (accept) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (step) begin
      acc_d = sum;
      cnt_d = last ? '0 : cnt_q + 1'b1;
      if (last) begin
        out_d = sat;
        ov_d  = 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      acc_q <= '0;
      out_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      out_q <= out_d;
      ov_q  <= ov_d;
    end
  end

  // Delay line: newest sample at x[0], shifted once per accepted input
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NPH; k++) x_q[k] <= '0;
    end else if (accept) begin
      for (int k = NPH-1; k > 0; k--) x_q[k] <= x_q[k-1];
      x_q[0] <= in_sample;
    end
  end

  assign coeff_addr    = cnt_q;
  assign current_count = cnt_q;
  assign out_sample    = out_q;
  assign out_valid     = ov_q;

endmodule

// File: doc/fir_phase_sequencer.md
Name: fir_phase_sequencer

Overview:
- Serial 64-phase FIR engine for one equalizer band. It runs one 6-bit phase count per sample.
- On the input side it accepts one audio sample through a valid/ready handshake, shifts it into a 64-entry delay line and walks phases 0..63.
- Each phase does one multiply-accumulate against an external coefficient ROM.
- After phase 63 it presents the saturated result on a valid/ready output handshake. It drives current_count, phase_0 and phase_63 for downstream phase-aligned logic.

Parameters:
- DATA_WIDTH, 16, signed sample width (Q1.15).
- COEFF_WIDTH, 16, signed coefficient width (Q1.15).
- ACC_WIDTH, 40, signed accumulator width.
- PHASE_WIDTH, 6, phase counter width. Phase count is fixed at 2**PHASE_WIDTH = 64.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- clk_enable  in  1  global advance enable; all state updates are qualified by it.
- in_sample  in  DATA_WIDTH  signed input sample.
- in_valid  in  1  in_sample is valid.
- in_ready  out  1  block accepts in_sample this cycle.
- coeff_addr  out  PHASE_WIDTH  coefficient ROM address; equals current_count.
- coeff_in  in  COEFF_WIDTH  signed coefficient, combinational ROM read of coeff_addr.
- out_sample  out  DATA_WIDTH  signed filtered sample.
- out_valid  out  1  out_sample is valid.
- out_ready  in  1  consumer takes out_sample.
- busy  out  1  high while in RUN.
- current_count  out  PHASE_WIDTH  current phase.
- phase_0  out  1  busy && current_count==0.
- phase_63  out  1  busy && current_count==63.

Behaviour:
- Reset (rst==0, asynchronous):
  - state=IDLE, current_count=0, acc=0.
  - All 64 delay-line entries = 0.
  - out_sample=0, out_valid=0.
  - Combinational outputs follow from these values: in_ready=0, busy=0, phase_0=0, phase_63=0.
- Reset mid-RUN aborts the computation. No output is produced and the delay line is cleared.
- clk_enable==0:
  - Nothing changes.
  - in_ready=0, so no input or output transfer occurs.
  - phase_0 and phase_63 hold their values.
- Output transfer: out_valid && out_ready && clk_enable. out_valid clears on that edge unless a new result is written on the same edge.
- in_ready = clk_enable && state==IDLE && (!out_valid || out_ready). This guarantees the result slot is free when the result lands.
- States:
  - IDLE:
    - Condition: in_valid && in_ready.
    - Action: x[k]<=x[k-1] for k=63..1; x[0]<=in_sample; acc<=0; current_count<=0; go RUN.
    - in_valid while not ready is ignored; the sample is neither captured nor dropped silently (the producer holds it).
  - RUN, each enabled cycle:
    - prod = x[current_count] * coeff_in, a signed full-precision 32-bit value, sign-extended to ACC_WIDTH.
    - If current_count<63: acc<=acc+prod and current_count<=current_count+1.
    - If current_count==63:
      - sum = acc + prod.
      - out_sample <= sat(sum >>> (COEFF_WIDTH-1)).
      - out_valid <= 1.
      - current_count <= 0.
      - state <= IDLE.
- Saturation: clamp the arithmetic-shifted sum to [-32768, 32767]. Results above clamp to 0x7FFF; results below clamp to 0x8000.
- Accumulator width: 40 bits cannot overflow for 64 products of 32 bits.
- Latency:
  - Input accepted at edge T.
  - Phases 0..63 occupy the enabled cycles after T.
  - out_valid rises at edge T+64 when clk_enable is continuously high; every disabled cycle adds one.
- Throughput: one sample per 65 enabled cycles when out_ready is held high. In IDLE, the next accept can happen in the same cycle as the output transfer.
- current_count wraps 63->0 only via the RUN exit. It is never incremented in IDLE.
- Simultaneous in_valid and the RUN phase-63 cycle: in_ready=0 (not IDLE), so the input is not accepted.

Test Plan:
- Impulse: after reset, all coeffs 0x4000; send 0x4000 then 0x0000 -> first out_sample=0x2000 with out_valid rising exactly 64 enabled cycles after accept; second out_sample=0x2000 (sample shifted to x[1]).
- Positive saturation: coeffs 0x7FFF; 64 samples of 0x7FFF -> out_sample reaches 0x7FFF (clamped) with no wrap; negative case with samples 0x8000 -> 0x8000.
- Back-pressure: hold out_ready=0 after first result; present in_valid -> in_ready stays 0 and out_sample stays stable; raise out_ready -> transfer and accept on the same edge.
- clk_enable gaps: drop clk_enable for 10 cycles at phase 30 -> current_count holds 30, phase strobes frozen, result identical, out_valid at accept+74.
- Phase strobes: during a run, phase_0 is high only on the first RUN cycle and phase_63 only on the last; both stay 0 in IDLE.
- Reset mid-run: assert rst at phase 30 -> out_valid stays 0, busy=0, count=0; next impulse 0x4000 with coeffs 0x4000 -> 0x2000 (delay line cleared).
